// File: rtl/bus_timer_pkg.sv
// Shared constants for the memory-mapped bus timer.
// Covers register offsets, CTRL bit positions, MODE encodings and FSM states.
package bus_timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM       = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

endpackage

// File: rtl/timer_byte_merge.sv
// Byte-lane merge: each enabled lane of new_word replaces the same lane of old_word.
module timer_byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  byteen,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byteen[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped down-counting timer with level interrupt, one-shot or auto-reload.
//   state | meaning
//   IDLE  | waiting for CTRL.EN
//   LOAD  | COUNT <= PRESET
//   CNT   | decrementing COUNT; terminal count at COUNT <= 1
//   INT   | flag raised; one-shot clears EN, auto-reload goes back to LOAD
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [31:0] BASE  = 32'h0000_7F00,
    parameter int          WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] preset_q, preset_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             irq_flag_q, irq_flag_d;
    timer_state_e     state_q, state_d;

    logic        win;
    logic [1:0]  sel;
    logic        wr_ctrl;
    logic        wr_preset;
    logic [31:0] merge_old;
    logic [31:0] merge_new;
    logic        unused_addr_lsb;

    assign win             = (addr[31:4] == BASE[31:4]);
    assign sel             = addr[3:2];
    assign wr_ctrl         = win && (byteen != 4'b0000) && (sel == REG_CTRL);
    assign wr_preset       = win && (byteen != 4'b0000) && (sel == REG_PRESET);
    assign merge_old       = (sel == REG_CTRL) ? {28'b0, ctrl_q} : 32'(preset_q);
    assign unused_addr_lsb = ^addr[1:0];

    timer_byte_merge u_merge (
        .old_word (merge_old),
        .new_word (wdata),
        .byteen   (byteen),
        .merged   (merge_new)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            state_q    <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN]) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = ST_IDLE;
                end else if (count_q > WIDTH'(1)) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = ST_INT;
                end
            end
            ST_INT: begin
                if (ctrl_q[CTRL_MODE_LSB +: 2] == MODE_RELOAD) begin
                    irq_flag_d = 1'b0;
                    state_d    = ST_LOAD;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus writes override the FSM's own CTRL/flag updates in the same cycle.
        if (wr_ctrl) begin
            ctrl_d     = merge_new[3:0];
            irq_flag_d = 1'b0;
        end
        if (wr_preset) begin
            preset_d = merge_new[WIDTH-1:0];
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (win) begin
            case (sel)
                REG_CTRL:   rdata = {28'b0, ctrl_q};
                REG_PRESET: rdata = 32'(preset_q);
                REG_COUNT:  rdata = 32'(count_q);
                default:    rdata = 32'h0;
            endcase
        end
    end

    assign irq = ctrl_q[CTRL_IM] & irq_flag_q;

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: directed scenarios plus random bus traffic
// compared against a cycle-level behavioural model of the register map and timer.
module tb_bus_timer;

    localparam logic [31:0] BASE   = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_PRE  = BASE + 32'h4;
    localparam logic [31:0] A_CNT  = BASE + 32'h8;
    localparam logic [31:0] A_RSV  = BASE + 32'hC;

    localparam int PH_IDLE  = 0;
    localparam int PH_LOAD  = 1;
    localparam int PH_COUNT = 2;
    localparam int PH_FIRE  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic [31:0] rdata;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    bit          m_flag;
    int          m_phase;

    bus_timer #(.BASE(BASE), .WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wdata  (wdata),
        .byteen (byteen),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return 32'h0;
        case (a[3:2])
            2'd0:    return {28'b0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_irq();
        return m_ctrl[3] & m_flag;
    endfunction

    task automatic m_reset();
        m_ctrl   = 4'h0;
        m_preset = 32'h0;
        m_count  = 32'h0;
        m_flag   = 1'b0;
        m_phase  = PH_IDLE;
    endtask

    // Advance the model by one rising edge, given the bus inputs present at that edge.
    task automatic m_edge(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
        logic [3:0]  c;
        logic [31:0] p, n, mc;
        bit          f, hit;
        int          ph;
        c = m_ctrl; p = m_preset; n = m_count; f = m_flag; ph = m_phase;
        case (m_phase)
            PH_IDLE:  if (m_ctrl[0]) ph = PH_LOAD;
            PH_LOAD:  begin n = m_preset; ph = PH_COUNT; end
            PH_COUNT: begin
                if (!m_ctrl[0]) ph = PH_IDLE;
                else if (m_count > 1) n = m_count - 1;
                else begin n = 0; f = 1'b1; ph = PH_FIRE; end
            end
            default: begin
                if (m_ctrl[2:1] == 2'b01) begin f = 1'b0; ph = PH_LOAD; end
                else begin c[0] = 1'b0; ph = PH_IDLE; end
            end
        endcase
        hit = (a[31:4] == BASE[31:4]) && (be != 4'b0000);
        if (hit && a[3:2] == 2'd0) begin
            mc = lanes({28'b0, m_ctrl}, w, be);
            c  = mc[3:0];
            f  = 1'b0;
        end
        if (hit && a[3:2] == 2'd1) p = lanes(m_preset, w, be);
        m_ctrl = c; m_preset = p; m_count = n; m_flag = f; m_phase = ph;
    endtask

    // One bus cycle: present inputs, take the edge, then check irq at the falling edge.
    task automatic tick(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
        addr = a; wdata = w; byteen = be;
        @(posedge clk);
        m_edge(a, w, be);
        @(negedge clk);
        addr = 32'h0; byteen = 4'h0;
        chk("irq", irq, m_irq());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(32'h0, 32'h0, 4'h0);
    endtask

    task automatic rd(input logic [31:0] a);
        addr = a; byteen = 4'h0;
        #1;
    endtask

    task automatic async_reset();
        reset = 1'b1;
        m_reset();
        #1 chk("rst_irq", irq, 0);
        rd(A_CTRL); chk("rst_ctrl", rdata, 0);
        rd(A_PRE);  chk("rst_preset", rdata, 0);
        rd(A_CNT);  chk("rst_count", rdata, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] a, w;
        logic [3:0]  be;
        reset = 1'b1; addr = 32'h0; wdata = 32'h0; byteen = 4'h0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("init_irq", irq, 0);
        rd(A_CTRL); chk("init_ctrl", rdata, 0);
        rd(A_CNT);  chk("init_count", rdata, 0);
        @(negedge clk);

        // One-shot, PRESET = 5: COUNT 5 at e0+2, 1 at e0+6, irq from e0+7, sticky.
        tick(A_PRE, 32'd5, 4'hF);
        tick(A_CTRL, 32'h9, 4'hF);
        idle(2);
        rd(A_CNT); chk("os_count_start", rdata, 5);
        idle(4);
        rd(A_CNT); chk("os_count_last", rdata, 1);
        chk("os_irq_before", irq, 0);
        idle(1);
        chk("os_irq_rise", irq, 1);
        idle(1);
        rd(A_CTRL); chk("os_ctrl_en_clr", rdata, 32'h8);
        idle(3);
        chk("os_irq_sticky", irq, 1);
        tick(A_CTRL, 32'h8, 4'h1);
        chk("os_irq_cleared", irq, 0);

        // Partial write to byte lane 2 only.
        tick(A_PRE, 32'h1122_3344, 4'hF);
        tick(A_PRE, 32'h00AA_0000, 4'b0100);
        rd(A_PRE); chk("partial_preset", rdata, 32'h11AA_3344);

        // Writes that must not change anything.
        tick(A_CNT, 32'hFFFF_FFFF, 4'hF);
        tick(A_RSV, 32'hFFFF_FFFF, 4'hF);
        tick(32'h0000_7F14, 32'hDEAD_BEEF, 4'hF);
        tick(32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
        rd(A_PRE);          chk("ign_preset", rdata, 32'h11AA_3344);
        rd(A_CNT);          chk("ign_count", rdata, 0);
        rd(A_RSV);          chk("rsvd_read", rdata, 0);
        @(negedge clk);
        rd(32'h0000_7F14);  chk("outside_read", rdata, 0);
        rd(A_CTRL);         chk("ign_ctrl", rdata, 32'h8);
        @(negedge clk);

        // Auto-reload, PRESET = 3: single-cycle pulse every 5 cycles.
        tick(A_PRE, 32'd3, 4'hF);
        tick(A_CTRL, 32'hB, 4'hF);
        for (int k = 1; k <= 20; k++) begin
            idle(1);
            chk("ar_pulse", irq, (k % 5 == 0) ? 32'd1 : 32'd0);
        end
        tick(A_CTRL, 32'h0, 4'hF);
        idle(4);

        // EN cleared as COUNT reaches 2: COUNT holds, no irq; re-enable reloads.
        tick(A_PRE, 32'd6, 4'hF);
        tick(A_CTRL, 32'h9, 4'hF);
        idle(5);
        tick(A_CTRL, 32'h8, 4'h1);
        idle(3);
        rd(A_CNT); chk("pause_hold", rdata, 2);
        chk("pause_no_irq", irq, 0);
        tick(A_CTRL, 32'h9, 4'h1);
        idle(2);
        rd(A_CNT); chk("restart_reload", rdata, 6);
        idle(6);
        chk("restart_irq", irq, 1);
        tick(A_CTRL, 32'h0, 4'h1);
        chk("restart_irq_clr", irq, 0);

        // IM = 0: flag sets silently; later run with IM = 1 raises irq.
        tick(A_PRE, 32'd2, 4'hF);
        tick(A_CTRL, 32'h1, 4'h1);
        idle(6);
        chk("im0_no_irq", irq, 0);
        rd(A_CTRL); chk("im0_en_clr", rdata, 0);
        tick(A_CTRL, 32'h9, 4'h1);
        idle(3);
        chk("im1_before", irq, 0);
        idle(1);
        chk("im1_irq", irq, 1);

        // Reset mid-count, checked before any clock edge.
        tick(A_PRE, 32'd50, 4'hF);
        tick(A_CTRL, 32'hB, 4'hF);
        idle(10);
        async_reset();

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 7))
                0:       a = BASE ^ (32'h1 << $urandom_range(4, 31));
                1, 2:    a = A_CTRL;
                3, 4:    a = A_PRE;
                5:       a = A_CNT;
                default: a = BASE + {28'h0, 4'($urandom_range(0, 15))};
            endcase
            be = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if (a[3:2] == 2'd1 && $urandom_range(0, 7) != 0) w = $urandom_range(0, 9);
            else w = $urandom;
            tick(a, w, be);
            a = BASE + {28'h0, 2'($urandom_range(0, 3)), 2'b00};
            rd(a); chk("rand_rdata", rdata, m_read(a));
            if ($urandom_range(0, 149) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
